tc0480scp_rom_cache: RTL and testbench
======================================

# tc0480scp_rom_cache

Direct-mapped read cache between the TC0480SCP background tile-ROM fetch port and the shared SDRAM ROM channel. It accepts the toggle-handshake 64-bit fetch requests that the tilemap chip issues on every BG tile row. Hits are answered from on-chip block RAM in 2 cycles; misses are forwarded over a toggle handshake to SDRAM. A flush sweep invalidates the cache after ROM download or reset.

## Interface

Parameters:
- INDEX_BITS, 6, log2 of line count; each line is one 64-bit word; tag = address[22:3+INDEX_BITS].

Ports:
- clk  in  1  system clock; block runs every cycle, no ce.
- reset  in  1  synchronous, active-high.
- flush  in  1  one-cycle pulse; invalidates all lines.
- rom_address  in  23  byte address from TC0480SCP; bits [2:0] ignored.
- rom_req  in  1  toggle; a request is pending while rom_req != rom_ack.
- rom_ack  out  1  toggle; set equal to rom_req when rom_data is valid.
- rom_data  out  64  fetched word; valid whenever rom_ack == rom_req.
- sdr_addr  out  23  SDRAM word address, bits [2:0] forced 0.
- sdr_req  out  1  toggle request to SDRAM.
- sdr_ack  in  1  toggle; sdr_data valid on the edge sdr_ack == sdr_req is first sampled.
- sdr_data  in  64  SDRAM read data.
- busy  out  1  high in FLUSH state.
- miss_count  out  16  saturating miss counter for debug.

## Operation

- Storage:
  - Data RAM: 2^INDEX_BITS x 64.
  - Tag RAM: 2^INDEX_BITS x (20-INDEX_BITS).
  - Valid bits in flops.
- States: FLUSH, IDLE, LOOKUP, COMPARE, FILL.
- FLUSH:
  - Entered on reset or flush.
  - Sweep counter clears one valid bit per cycle, index 0 to 2^INDEX_BITS-1.
  - Goes to IDLE after the last index.
  - Pending rom_req is held, not dropped.
- IDLE: on rom_req != rom_ack, latch rom_address into addr_q, issue RAM read at addr_q index, go to LOOKUP.
- LOOKUP: RAM output settles; go to COMPARE.
- COMPARE:
  - Hit (valid & tag match): rom_data <= data RAM word, rom_ack <= rom_req, go to IDLE.
  - Miss: sdr_addr <= {addr_q[22:3],3'b0}, sdr_req <= ~sdr_req, miss_count += 1 (saturates at 16'hFFFF), go to FILL.
- FILL: on the first edge sampling sdr_ack == sdr_req:
  - Write sdr_data and tag to the line; set valid.
  - rom_data <= sdr_data, rom_ack <= rom_req.
  - Go to IDLE.
- Requests are serviced strictly one at a time. rom_address must be stable from the rom_req toggle until rom_ack matches; TC0480SCP guarantees this.
- Flush arriving in IDLE, LOOKUP or COMPARE: abandon lookup without acking, enter FLUSH; the request is re-looked-up afterwards.
- Flush arriving in FILL:
  - Set flush_pend; wait for sdr_ack.
  - Deliver rom_data and toggle rom_ack, but do not write valid/tag.
  - Then enter FLUSH.
- Reset and flush together: reset wins; identical outcome.
- Reset mid-FILL: transaction abandoned. The SDRAM channel is reset in the same domain, so toggle state restarts at 0 on both sides.

## Timing

- Reset values:
  - rom_ack 0, rom_data 0, sdr_req 0, sdr_addr 0, miss_count 0.
  - busy 1 (FLUSH); all valid 0.
- Flush duration: 2^INDEX_BITS cycles (64 by default), busy high throughout, then 1 cycle to IDLE.
- Hit latency: rom_req toggle sampled at edge E0 (IDLE). rom_ack and rom_data update at edge E2.
- Miss: sdr_req toggles at E2. rom_ack toggles on the same edge sdr_ack == sdr_req is first sampled. Total = 2 + SDRAM latency.
- A back-to-back request whose rom_req toggles in the ack cycle is sampled the next edge. Minimum hit-to-hit spacing is 3 cycles.
- rom_data never changes while rom_ack == rom_req except in the ack cycle itself.

## Test plan

- Reset 1 cycle, then toggle rom_req with rom_address=23'h012340 -> busy high 64 cycles. Then sdr_req toggles with sdr_addr=23'h012340. Return sdr_data=64'hDEADBEEF_01234567 -> rom_ack matches, rom_data equal, miss_count=1.
- Repeat request 23'h012345 -> hit: no sdr_req toggle; rom_ack 2 cycles after sampling; data 64'hDEADBEEF_01234567; miss_count stays 1.
- Request 23'h012340 + (1<<9) (same index, different tag) -> miss and refill. Then the original address misses again; miss_count=3.
- Pulse flush while in FILL with SDRAM latency 10 -> rom_ack delivered with SDRAM data. Then a 64-cycle sweep; the same address next misses.
- Assert reset during FILL -> all outputs return to reset values next edge; sweep restarts; the later sdr_ack toggle is ignored.
- Force miss_count to 16'hFFFE via 65534 distinct-tag misses (or a backdoor preload) -> two more misses saturate at 16'hFFFF.

Source files
------------

// File: rtl/tc0480scp_rom_cache.sv
// Direct-mapped 64-bit word cache between the TC0480SCP tile-ROM port and SDRAM.
// Latency: hit acks 2 edges after the rom_req toggle is sampled; miss acks on the edge that sees sdr_ack == sdr_req.
// Backpressure: toggle handshakes on both sides, one request in flight; requests are held (not dropped) during a flush sweep.
module tc0480scp_rom_cache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [22:0] rom_address,
    input  logic        rom_req,
    output logic        rom_ack,
    output logic [63:0] rom_data,
    output logic [22:0] sdr_addr,
    output logic        sdr_req,
    input  logic        sdr_ack,
    input  logic [63:0] sdr_data,
    output logic        busy,
    output logic [15:0] miss_count
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 20 - INDEX_BITS;

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        LOOKUP,
        COMPARE,
        FILL
    } state_t;

    state_t                  state;
    logic [19:0]             word_q;
    logic [INDEX_BITS-1:0]   sweep_idx;
    logic [LINES-1:0]        valid;
    logic                    flush_pend;
    logic [15:0]             miss_cnt_q;

    logic [63:0]             data_ram [LINES];
    logic [TAG_W-1:0]        tag_ram  [LINES];
    logic [63:0]             ram_dat;
    logic [TAG_W-1:0]        ram_tag;

    logic [INDEX_BITS-1:0]   idx;
    logic [TAG_W-1:0]        tag;
    logic                    sdr_done;
    logic                    fill_wr;
    logic                    hit;
    wire                     unused_low = ^rom_address[2:0];

    assign idx      = word_q[INDEX_BITS-1:0];
    assign tag      = word_q[19 -: TAG_W];
    assign sdr_done = (sdr_ack == sdr_req);
    assign hit      = valid[idx] && (ram_tag == tag);
    // A flush seen during or at the end of a fill still returns the data but must not install the line.
    assign fill_wr  = !reset && (state == FILL) && sdr_done && !flush && !flush_pend;

    assign busy       = (state == FLUSH);
    assign miss_count = miss_cnt_q;

    // Line storage has no reset; the valid flops alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            data_ram[idx] <= sdr_data;
            tag_ram[idx]  <= tag;
        end
        ram_dat <= data_ram[idx];
        ram_tag <= tag_ram[idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FLUSH;
            sweep_idx  <= '0;
            valid      <= '0;
            flush_pend <= 1'b0;
            word_q     <= '0;
            rom_ack    <= 1'b0;
            rom_data   <= '0;
            sdr_req    <= 1'b0;
            sdr_addr   <= '0;
            miss_cnt_q <= '0;
        end else if (flush && state != FILL) begin
            // Any lookup in progress is abandoned unacked and retried after the sweep.
            state     <= FLUSH;
            sweep_idx <= '0;
        end else begin
            case (state)
                FLUSH: begin
                    valid[sweep_idx] <= 1'b0;
                    sweep_idx        <= sweep_idx + 1'b1;
                    if (&sweep_idx) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (rom_req != rom_ack) begin
                        word_q <= rom_address[22:3];
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    state <= COMPARE;
                end
                COMPARE: begin
                    if (hit) begin
                        rom_data <= ram_dat;
                        rom_ack  <= rom_req;
                        state    <= IDLE;
                    end else begin
                        sdr_addr <= {word_q, 3'b000};
                        sdr_req  <= ~sdr_req;
                        if (miss_cnt_q != 16'hFFFF) begin
                            miss_cnt_q <= miss_cnt_q + 16'd1;
                        end
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (sdr_done) begin
                        rom_data <= sdr_data;
                        rom_ack  <= rom_req;
                        if (flush || flush_pend) begin
                            flush_pend <= 1'b0;
                            sweep_idx  <= '0;
                            state      <= FLUSH;
                        end else begin
                            valid[idx] <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    sweep_idx <= '0;
                    state     <= FLUSH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tc0480scp_rom_cache.sv
// Scoreboarded bench for tc0480scp_rom_cache: an abstract cache model predicts data, latency and miss count.
module tb_tc0480scp_rom_cache;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [22:0] rom_address;
    logic        rom_req;
    logic        rom_ack;
    logic [63:0] rom_data;
    logic [22:0] sdr_addr;
    logic        sdr_req;
    logic        sdr_ack;
    logic [63:0] sdr_data;
    logic        busy;
    logic [15:0] miss_count;

    always #5 clk = ~clk;

    tc0480scp_rom_cache #(.INDEX_BITS(6)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .rom_address(rom_address), .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data),
        .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_ack(sdr_ack), .sdr_data(sdr_data),
        .busy(busy), .miss_count(miss_count)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q [$];
    logic [63:0] mem [logic [19:0]];
    bit          m_valid [64];
    logic [13:0] m_tag   [64];
    logic [63:0] m_data  [64];
    int          mc;
    int          sdr_lat = 0;
    logic [22:0] cur_addr = '0;

    function automatic logic [63:0] rom_word(input logic [19:0] w);
        if (mem.exists(w)) return mem[w];
        return {12'hA5C, w, ~w, 12'h3C5};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic model_invalidate();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_rom_ack",    64'(rom_ack),    64'd0);
        check("rst_rom_data",   rom_data,        64'd0);
        check("rst_sdr_req",    64'(sdr_req),    64'd0);
        check("rst_sdr_addr",   64'(sdr_addr),   64'd0);
        check("rst_miss_count", 64'(miss_count), 64'd0);
        check("rst_busy",       64'(busy),       64'd1);
    endtask

    task automatic count_busy(input int want);
        int n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'(want));
    endtask

    // flush_at: negedge count after the toggle at which a one-cycle flush pulse is driven (-1 none).
    task automatic do_req(input logic [22:0] a, input int flush_at, input int lat_override);
        int          idx;
        logic [13:0] tg;
        bit          hit;
        logic [63:0] e;
        logic        s0;
        int          n;
        int          want;
        idx = int'(a[8:3]);
        tg  = a[22:9];
        if (flush_at >= 0 && flush_at < 3) model_invalidate();
        hit = m_valid[idx] && (m_tag[idx] == tg);
        e   = hit ? m_data[idx] : rom_word(a[22:3]);
        if (!hit && mc < 65535) mc++;
        want = (lat_override >= 0) ? lat_override : (hit ? 3 : 4 + sdr_lat);
        cur_addr = a;
        s0 = sdr_req;
        exp_q.push_back(e);
        rom_address = a;
        rom_req = ~rom_req;
        n = 0;
        while (rom_ack !== rom_req && n < 300) begin
            @(negedge clk);
            n++;
            flush = (n == flush_at);
        end
        flush = 1'b0;
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL req_timeout: addr=%h no ack after %0d cycles", a, n);
        end
        check("latency",    64'(n),             64'(want));
        check("sdr_toggle", 64'(sdr_req ^ s0),  64'(!hit));
        check("miss_count", 64'(miss_count),    64'(mc));
        if (flush_at >= 3) begin
            model_invalidate();
        end else if (!hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_data[idx]  = e;
        end
    endtask

    // Scoreboard monitor: every rom_ack change pops one expected word; otherwise rom_data must hold.
    initial begin : monitor
        logic        pa;
        logic [63:0] pd;
        logic [63:0] e;
        pa = 1'b0;
        pd = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                pa = rom_ack;
                pd = rom_data;
            end else if (rom_ack !== pa) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: rom_ack=%0b with nothing outstanding", rom_ack);
                end else begin
                    e = exp_q.pop_front();
                    check("rom_data", rom_data, e);
                end
                pa = rom_ack;
                pd = rom_data;
            end else begin
                check("rom_data_hold", rom_data, pd);
            end
        end
    end

    // SDRAM responder: answers each sdr_req toggle after sdr_lat cycles; reset cancels it.
    initial begin : sdram
        bit pend;
        int cnt;
        pend = 1'b0;
        cnt = 0;
        sdr_ack = 1'b0;
        sdr_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                pend = 1'b0;
                sdr_ack = 1'b0;
            end else begin
                if (!pend && sdr_req != sdr_ack) begin
                    pend = 1'b1;
                    cnt = sdr_lat;
                    check("sdr_addr", 64'(sdr_addr), 64'({cur_addr[22:3], 3'b000}));
                end
                if (pend) begin
                    if (cnt == 0) begin
                        sdr_data = rom_word(sdr_addr[22:3]);
                        sdr_ack = sdr_req;
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [22:0] a;
        logic [13:0] tags [3];
        int          idxs [4];
        tags[0] = 14'h0001; tags[1] = 14'h0ABC; tags[2] = 14'h3FFF;
        idxs[0] = 0; idxs[1] = 5; idxs[2] = 63; idxs[3] = 17;
        reset = 1'b1;
        flush = 1'b0;
        rom_req = 1'b0;
        rom_address = '0;
        mc = 0;
        model_invalidate();
        mem[20'h02468] = 64'hDEADBEEF_01234567;
        @(negedge clk);
        check_reset_vals();
        reset = 1'b0;

        // Request issued during the power-up sweep: 64 sweep cycles, lookup, miss, zero-latency fill.
        sdr_lat = 0;
        do_req(23'h012340, -1, 68);
        mem[20'h02468] = {$urandom, $urandom};
        do_req(23'h012345, -1, -1);
        do_req(23'h012340 + 23'(1 << 9), -1, -1);
        do_req(23'h012340, -1, -1);

        // Flush pulse during a 10-cycle fill: data is delivered, nothing installed, then a full sweep.
        sdr_lat = 10;
        do_req(23'h034560, 4, -1);
        count_busy(64);
        sdr_lat = 0;
        do_req(23'h034560, -1, -1);

        // Flush during LOOKUP: request abandoned, retried after the sweep, and misses.
        do_req(23'h012340, 1, 70);

        for (int i = 0; i < 40; i++) begin
            sdr_lat = $urandom_range(0, 4);
            a = {tags[$urandom_range(0, 2)], 6'(idxs[$urandom_range(0, 3)]), 3'($urandom_range(0, 7))};
            if ($urandom_range(0, 3) == 0) mem[a[22:3]] = {$urandom, $urandom};
            do_req(a, -1, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a fill: everything returns to reset values and the sweep restarts.
        sdr_lat = 10;
        a = 23'h055558;
        cur_addr = a;
        rom_address = a;
        rom_req = ~rom_req;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        rom_req = 1'b0;
        @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        mc = 0;
        model_invalidate();
        count_busy(64);
        check("post_reset_ack", 64'(rom_ack), 64'd0);
        sdr_lat = 2;
        do_req(a, -1, -1);

        // Miss counter saturation.
        @(negedge clk);
        force dut.miss_cnt_q = 16'hFFFE;
        #1;
        release dut.miss_cnt_q;
        mc = 65534;
        sdr_lat = 1;
        do_req(23'h700000, -1, -1);
        do_req(23'h710000, -1, -1);
        do_req(23'h720000, -1, -1);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
